// File: rtl/cpu_core_param_if.sv
// Debug/serial bus of the parametrised CPU core. The master drives the serial frame and
// the debug select. The slave (the core) returns the debug value and its status.
interface cpu_core_param_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              start_i;
  logic              bit_i;
  logic [3:0]        dbg_sel_i;
  logic [DATA_W-1:0] out_o;
  logic [3:0]        flags_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  modport master (
    output start_i, bit_i, dbg_sel_i,
    input  out_o, flags_o, busy_o, done_o, err_o
  );

  modport slave (
    input  start_i, bit_i, dbg_sel_i,
    output out_o, flags_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/cpu_core_param.sv
// Serial-loaded CPU core. A frame arrives MSB first: {op, dst, src, imm}. The frame executes
// against an NREGS-entry register file. The flags, the pc and the last op/result are then
// updated and can be read back through the debug select.
module cpu_core_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  cpu_core_param_if.slave  bus
);
  localparam int unsigned RIDX_W  = $clog2(NREGS);
  localparam int unsigned FRAME_W = 4 + 2 * RIDX_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W);
  localparam int unsigned MSB     = DATA_W - 1;

  typedef enum logic [1:0] {StIdle, StShift, StExec, StDone} state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  regs_q [NREGS];
  logic [3:0]         flags_q;
  logic [DATA_W-1:0]  pc_q;
  logic [3:0]         lastop_q;
  logic [DATA_W-1:0]  res_q;
  logic               err_q;

  // Frame fields
  logic [3:0]        op;
  logic [RIDX_W-1:0] dst, src;
  logic [DATA_W-1:0] imm;
  assign op  = frame_q[FRAME_W-1 -: 4];
  assign dst = frame_q[DATA_W+RIDX_W +: RIDX_W];
  assign src = frame_q[DATA_W +: RIDX_W];
  assign imm = frame_q[DATA_W-1:0];

  logic [DATA_W-1:0] alu_a, alu_b, alu_opb, alu_res;
  logic [DATA_W:0]   alu_sum, alu_diff;
  logic              alu_c, alu_v, alu_wr, alu_upd;

  // ALU: INC/DEC reuse the add/sub paths with a constant 1 operand
  always_comb begin
    alu_a    = regs_q[dst];
    alu_b    = regs_q[src];
    alu_opb  = (op == 4'd10 || op == 4'd11) ? DATA_W'(1) : alu_b;
    alu_sum  = {1'b0, alu_a} + {1'b0, alu_opb};
    alu_diff = {1'b0, alu_a} - {1'b0, alu_opb};
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_wr   = 1'b0;
    alu_upd  = 1'b0;
    case (op)
      4'd1: begin alu_res = imm;   alu_wr = 1'b1; end
      4'd2: begin alu_res = alu_b; alu_wr = 1'b1; end
      4'd3, 4'd10: begin
        alu_res = alu_sum[DATA_W-1:0];
        alu_c   = alu_sum[DATA_W];
        alu_v   = (alu_a[MSB] == alu_opb[MSB]) && (alu_res[MSB] != alu_a[MSB]);
        alu_wr  = 1'b1;
        alu_upd = 1'b1;
      end
      4'd4, 4'd11, 4'd12: begin
        alu_res = alu_diff[DATA_W-1:0];
        alu_c   = alu_diff[DATA_W];  // borrow
        alu_v   = (alu_a[MSB] != alu_opb[MSB]) && (alu_res[MSB] != alu_a[MSB]);
        alu_wr  = (op != 4'd12);
        alu_upd = 1'b1;
      end
      4'd5: begin alu_res = alu_a & alu_b; alu_wr = 1'b1; alu_upd = 1'b1; end
      4'd6: begin alu_res = alu_a | alu_b; alu_wr = 1'b1; alu_upd = 1'b1; end
      4'd7: begin alu_res = alu_a ^ alu_b; alu_wr = 1'b1; alu_upd = 1'b1; end
      4'd8: begin
        alu_res = {alu_a[DATA_W-2:0], 1'b0};
        alu_c   = alu_a[MSB];
        alu_wr  = 1'b1;
        alu_upd = 1'b1;
      end
      4'd9: begin
        alu_res = {1'b0, alu_a[DATA_W-1:1]};
        alu_c   = alu_a[0];
        alu_wr  = 1'b1;
        alu_upd = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state logic: idle -> shift FRAME_W bits -> exec -> done
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          state_d = StShift;
          cnt_d   = '0;
        end
      end
      StShift: begin
        frame_d = {frame_q[FRAME_W-2:0], bus.bit_i};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(FRAME_W - 1)) state_d = StExec;
      end
      StExec:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      frame_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
    end
  end

  // Architectural state, committed only in EXEC
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      flags_q  <= '0;
      pc_q     <= '0;
      lastop_q <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else if (state_q == StExec) begin
      if (alu_wr)  regs_q[dst] <= alu_res;
      if (alu_upd) flags_q <= {alu_res[MSB], alu_v, (alu_res == '0), alu_c};
      if (op >= 4'd13) err_q <= 1'b1;
      pc_q     <= pc_q + 1'b1;
      lastop_q <= op;
      res_q    <= alu_res;
    end
  end

  // Debug output mux
  always_comb begin
    bus.out_o = '0;
    if (32'(bus.dbg_sel_i) < NREGS) begin
      bus.out_o = regs_q[bus.dbg_sel_i[RIDX_W-1:0]];
    end else begin
      case (bus.dbg_sel_i)
        4'd12:   bus.out_o = DATA_W'(lastop_q);
        4'd13:   bus.out_o = res_q;
        4'd14:   bus.out_o = pc_q;
        4'd15:   bus.out_o = DATA_W'(flags_q);
        default: bus.out_o = '0;
      endcase
    end
  end

  assign bus.flags_o = flags_q;
  assign bus.busy_o  = (state_q == StShift) || (state_q == StExec);
  assign bus.done_o  = (state_q == StDone);
  assign bus.err_o   = err_q;
endmodule

// File: tb/tb_cpu_core_param.sv
// Bench for cpu_core_param: two instances (8-bit/4 regs and 4-bit/8 regs) checked against
// an integer-arithmetic model of the instruction set.
module tb_cpu_core_param;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  cpu_core_param_if #(.DATA_W(8)) ifa ();
  cpu_core_param_if #(.DATA_W(4)) ifb ();

  cpu_core_param #(.DATA_W(8), .NREGS(4)) dut_a (.clk_i(clk), .rst_ni(rst_a), .bus(ifa.slave));
  cpu_core_param #(.DATA_W(4), .NREGS(8)) dut_b (.clk_i(clk), .rst_ni(rst_b), .bus(ifb.slave));

  int tests = 0;
  int fails = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b
  int mregs [2][8];
  int mflags [2];
  int mpc [2];
  int merr [2];
  int mlastop [2];
  int mres [2];

  function automatic int wd(input int d); return d ? 4 : 8; endfunction
  function automatic int nr(input int d); return d ? 8 : 4; endfunction
  function automatic int rw(input int d); return d ? 3 : 2; endfunction
  function automatic int fw(input int d); return 4 + 2 * rw(d) + wd(d); endfunction

  function automatic logic [31:0] g_out(input int d);
    return d ? 32'(ifb.out_o) : 32'(ifa.out_o);
  endfunction
  function automatic logic [31:0] g_flags(input int d);
    return d ? 32'(ifb.flags_o) : 32'(ifa.flags_o);
  endfunction
  function automatic logic [31:0] g_busy(input int d);
    return d ? 32'(ifb.busy_o) : 32'(ifa.busy_o);
  endfunction
  function automatic logic [31:0] g_done(input int d);
    return d ? 32'(ifb.done_o) : 32'(ifa.done_o);
  endfunction
  function automatic logic [31:0] g_err(input int d);
    return d ? 32'(ifb.err_o) : 32'(ifa.err_o);
  endfunction

  task automatic drv(input int d, input logic st, input logic bt);
    if (d != 0) begin ifb.start_i = st; ifb.bit_i = bt; end
    else begin ifa.start_i = st; ifa.bit_i = bt; end
  endtask

  task automatic set_sel(input int d, input int s);
    if (d != 0) ifb.dbg_sel_i = 4'(s);
    else ifa.dbg_sel_i = 4'(s);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset(input int d);
    for (int i = 0; i < 8; i++) mregs[d][i] = 0;
    mflags[d] = 0; mpc[d] = 0; merr[d] = 0; mlastop[d] = 0; mres[d] = 0;
  endfunction

  function automatic int sgn(input int x, input int m);
    return (x >= m / 2) ? x - m : x;
  endfunction

  // Instruction semantics in plain integer arithmetic
  function automatic void model_exec(input int d, input int op, input int dst, input int src,
                                     input int imm);
    int m, a, b, r, full, s, c, v;
    bit wr, upd;
    m = 1 << wd(d);
    a = mregs[d][dst];
    b = mregs[d][src];
    r = 0; c = 0; v = 0; wr = 0; upd = 0;
    case (op)
      1: begin r = imm; wr = 1; end
      2: begin r = b; wr = 1; end
      3, 10: begin
        if (op == 10) b = 1;
        full = a + b; r = full % m; c = (full >= m) ? 1 : 0;
        s = sgn(a, m) + sgn(b, m); v = (s < -(m / 2) || s > m / 2 - 1) ? 1 : 0;
        wr = 1; upd = 1;
      end
      4, 11, 12: begin
        if (op == 11) b = 1;
        r = (a - b + m) % m; c = (a < b) ? 1 : 0;
        s = sgn(a, m) - sgn(b, m); v = (s < -(m / 2) || s > m / 2 - 1) ? 1 : 0;
        wr = (op != 12); upd = 1;
      end
      5: begin r = a & b; wr = 1; upd = 1; end
      6: begin r = a | b; wr = 1; upd = 1; end
      7: begin r = a ^ b; wr = 1; upd = 1; end
      8: begin r = (a * 2) % m; c = (a >= m / 2) ? 1 : 0; wr = 1; upd = 1; end
      9: begin r = a / 2; c = a % 2; wr = 1; upd = 1; end
      default: ;
    endcase
    if (wr) mregs[d][dst] = r;
    if (upd) mflags[d] = ((r >= m / 2) ? 8 : 0) | (v * 4) | ((r == 0) ? 2 : 0) | c;
    if (op >= 13) merr[d] = 1;
    mpc[d] = (mpc[d] + 1) % m;
    mlastop[d] = op;
    mres[d] = r;
  endfunction

  // Shift one frame in and wait for done; lat is the edge count from the start edge
  task automatic send(input int d, input int op, input int dst, input int src, input int imm,
                      input bit hold, output int lat);
    logic [31:0] fr;
    int f;
    f = fw(d);
    fr = (32'(op) << (2 * rw(d) + wd(d))) | (32'(dst) << (rw(d) + wd(d)))
         | (32'(src) << wd(d)) | 32'(imm);
    lat = -1;
    @(negedge clk);
    drv(d, 1'b1, 1'b0);
    for (int e = 1; e <= 40 && lat < 0; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e <= f) drv(d, hold, fr[f-e]);
      if (g_done(d) == 32'd1) lat = e;
    end
    drv(d, 1'b0, 1'b0);
    if (lat < 0) check("done_timeout", 32'(lat), 32'(f + 2));
    model_exec(d, op, dst, src, imm);
  endtask

  // Full state comparison right after a done pulse
  task automatic frame_check(input int d, input int lat);
    check($sformatf("latency d%0d", d), 32'(lat), 32'(fw(d) + 2));
    @(negedge clk);
    check($sformatf("done_pulse d%0d", d), g_done(d), 32'd0);
    check($sformatf("busy_idle d%0d", d), g_busy(d), 32'd0);
    for (int s = 0; s < nr(d); s++) begin
      set_sel(d, s); #1;
      check($sformatf("d%0d r%0d", d, s), g_out(d), 32'(mregs[d][s]));
    end
    set_sel(d, 12); #1; check($sformatf("d%0d lastop", d), g_out(d), 32'(mlastop[d]));
    if (mlastop[d] >= 1 && mlastop[d] <= 12) begin
      set_sel(d, 13); #1; check($sformatf("d%0d lastres", d), g_out(d), 32'(mres[d]));
    end
    set_sel(d, 14); #1; check($sformatf("d%0d pc", d), g_out(d), 32'(mpc[d]));
    set_sel(d, 15); #1; check($sformatf("d%0d sel15", d), g_out(d), 32'(mflags[d]));
    check($sformatf("d%0d flags", d), g_flags(d), 32'(mflags[d]));
    check($sformatf("d%0d err", d), g_err(d), 32'(merr[d]));
  endtask

  task automatic run(input int d, input int op, input int dst, input int src, input int imm);
    int lat;
    send(d, op, dst, src, imm, 1'b0, lat);
    frame_check(d, lat);
  endtask

  initial begin
    int lat, seen;
    logic [31:0] fr;
    rst_a = 1'b0; rst_b = 1'b0;
    drv(0, 1'b0, 1'b0); drv(1, 1'b0, 1'b0);
    set_sel(0, 0); set_sel(1, 0);
    model_reset(0); model_reset(1);
    repeat (3) @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);

    // Reset state on every select
    for (int s = 0; s < 16; s++) begin
      set_sel(0, s); #1;
      check($sformatf("reset sel%0d", s), g_out(0), 32'd0);
    end
    check("reset flags", g_flags(0), 32'd0);
    check("reset busy", g_busy(0), 32'd0);
    check("reset err", g_err(0), 32'd0);
    check("reset done", g_done(0), 32'd0);

    // ADD with signed overflow
    run(0, 1, 0, 0, 8'h7F);
    run(0, 1, 1, 0, 8'h01);
    run(0, 3, 0, 1, 8'h00);
    set_sel(0, 0); #1; check("add r0", g_out(0), 32'h80);
    check("add flags", g_flags(0), 32'b1100);
    set_sel(0, 14); #1; check("add pc", g_out(0), 32'd3);

    // SUB to zero, then CMP without writeback
    run(0, 1, 2, 0, 8'h05);
    run(0, 4, 2, 2, 8'h00);
    check("sub flags", g_flags(0), 32'b0010);
    run(0, 12, 1, 2, 8'h00);
    check("cmp flags", g_flags(0), 32'b0000);
    set_sel(0, 1); #1; check("cmp r1", g_out(0), 32'h01);
    set_sel(0, 2); #1; check("cmp r2", g_out(0), 32'h00);

    // Illegal opcode is sticky; a later ADD still executes
    run(0, 14, 0, 1, 8'hAA);
    check("illegal err", g_err(0), 32'd1);
    run(0, 3, 1, 1, 8'h00);
    check("post-illegal err", g_err(0), 32'd1);

    // start held high through the frame: one execution only
    send(0, 10, 3, 0, 8'h00, 1'b1, lat);
    frame_check(0, lat);
    repeat (5) @(negedge clk);
    check("hold busy", g_busy(0), 32'd0);
    set_sel(0, 14); #1; check("hold pc", g_out(0), 32'(mpc[0]));

    // Reset in the middle of a frame abandons it
    fr = 32'h1055;
    @(negedge clk);
    drv(0, 1'b1, 1'b0);
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      @(negedge clk);
      drv(0, 1'b0, fr[16-e]);
    end
    rst_a = 1'b0;
    #1;
    model_reset(0);
    check("midreset busy", g_busy(0), 32'd0);
    check("midreset err", g_err(0), 32'd0);
    @(negedge clk);
    rst_a = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (g_done(0) == 32'd1) seen++;
    end
    check("midreset no done", 32'(seen), 32'd0);
    set_sel(0, 0); #1; check("midreset r0", g_out(0), 32'd0);

    // Randomized frames on the 8-bit core
    for (int i = 0; i < 40; i++)
      run(0, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 255));

    // pc wrap from 0xFF to 0x00
    while (mpc[0] != 255) begin
      send(0, 0, 0, 0, 0, 1'b0, lat);
    end
    set_sel(0, 14); #1; check("pc at ff", g_out(0), 32'hFF);
    run(0, 0, 0, 0, 0);
    set_sel(0, 14); #1; check("pc wrap", g_out(0), 32'h00);

    // 4-bit, 8-register core: SHL 0x9 -> 0x2 with carry
    run(1, 1, 5, 0, 4'h9);
    run(1, 8, 5, 0, 4'h0);
    set_sel(1, 5); #1; check("b shl r5", g_out(1), 32'h2);
    check("b shl flags", g_flags(1), 32'b0001);
    for (int i = 0; i < 30; i++)
      run(1, $urandom_range(0, 12), $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 15));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
